screen_fb: RTL

Parametrised bitmap framebuffer with an integrated raster timing generator, a CPU word port and a pixel scan-out pipeline. It is the successor of the fixed 512x256 1-bit Hack screen. Resolution, sync timing, pixel clock division, bits per pixel and sync polarity are all parameters. It sits on the memory-mapped screen segment of the CPU bus and drives the video DAC/encoder pins directly.

---
 rtl/screen_fb.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/screen_fb.sv
// rtl/screen_fb.sv - bitmap framebuffer with raster timing, CPU word port and pixel scan-out
module screen_fb #(
    parameter int   WORD_W   = 16,
    parameter int   H_ACTIVE = 512,
    parameter int   V_ACTIVE = 256,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   BPP      = 1,
    parameter int   PIX_DIV  = 2,
    parameter logic SYNC_POL = 1'b0,
    parameter int   ADDR_W   = $clog2(H_ACTIVE * V_ACTIVE * BPP / WORD_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WORD_W-1:0] out,
    output logic [BPP-1:0]    r,
    output logic [BPP-1:0]    g,
    output logic [BPP-1:0]    b,
    output logic              hsync,
    output logic              vsync,
    output logic              hblank,
    output logic              vblank,
    output logic              pix_ce,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PPW     = WORD_W / BPP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int DEPTH   = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [DW-1:0]     div_q, div_d;
    logic              pix_ce_q, pix_ce_d;
    logic [HW-1:0]     hpos_q, hpos_d;
    logic [VW-1:0]     vpos_q, vpos_d;
    logic [PW-1:0]     wpix_q, wpix_d;
    logic [ADDR_W-1:0] vaddr_q, vaddr_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [PW-1:0]     sel_q, sel_d;
    logic              act1_q, act1_d, hb1_q, hb1_d, vb1_q, vb1_d;
    logic              hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic [BPP-1:0]    pix_q, pix_d;
    logic              hsync_q, hsync_d, vsync_q, vsync_d;
    logic              hblank_q, hblank_d, vblank_q, vblank_d;
    logic              frame_start_q, frame_start_d;
    logic              active_c, word_last_c;

    always_ff @(posedge clk) begin
        if (load) mem[address] <= in;
    end

    always_comb begin
        div_d = div_q;       pix_ce_d = 1'b0;
        hpos_d = hpos_q;     vpos_d = vpos_q;
        wpix_d = wpix_q;     vaddr_d = vaddr_q;
        word_d = word_q;     sel_d = sel_q;
        act1_d = act1_q;     hb1_d = hb1_q;      vb1_d = vb1_q;
        hs1_d = hs1_q;       vs1_d = vs1_q;      fs1_d = fs1_q;
        pix_d = pix_q;       hsync_d = hsync_q;  vsync_d = vsync_q;
        hblank_d = hblank_q; vblank_d = vblank_q;
        frame_start_d = frame_start_q;
        out_d = load ? out_q : mem[address];
        active_c    = (int'(hpos_q) < H_ACTIVE) && (int'(vpos_q) < V_ACTIVE);
        word_last_c = active_c && (int'(wpix_q) == PPW - 1);

        if (int'(div_q) == PIX_DIV - 1) begin
            div_d    = '0;
            pix_ce_d = 1'b1;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (pix_ce_q) begin
            // Stage 1: decode the counter position; fetch a word only on its first pixel
            act1_d = active_c;
            hb1_d  = int'(hpos_q) >= H_ACTIVE;
            vb1_d  = int'(vpos_q) >= V_ACTIVE;
            hs1_d  = (int'(hpos_q) >= H_ACTIVE + H_FP) && (int'(hpos_q) < H_ACTIVE + H_FP + H_SYNC);
            vs1_d  = (int'(vpos_q) >= V_ACTIVE + V_FP) && (int'(vpos_q) < V_ACTIVE + V_FP + V_SYNC);
            fs1_d  = (hpos_q == '0) && (vpos_q == '0);
            sel_d  = wpix_q;
            if (active_c && (wpix_q == '0)) word_d = mem[vaddr_q];

            // Stage 2: drive the pins
            pix_d         = act1_q ? word_q[sel_q*BPP +: BPP] : '0;
            hblank_d      = hb1_q;
            vblank_d      = vb1_q;
            hsync_d       = hs1_q ? SYNC_POL : ~SYNC_POL;
            vsync_d       = vs1_q ? SYNC_POL : ~SYNC_POL;
            frame_start_d = fs1_q;

            if (int'(hpos_q) == H_TOTAL - 1) begin
                hpos_d = '0;
                vpos_d = (int'(vpos_q) == V_TOTAL - 1) ? '0 : vpos_q + 1'b1;
            end else begin
                hpos_d = hpos_q + 1'b1;
            end
            if (active_c) wpix_d = word_last_c ? '0 : wpix_q + 1'b1;
            if ((hpos_d == '0) && (vpos_d == '0)) vaddr_d = '0;
            else if (word_last_c)                  vaddr_d = vaddr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= '0;     pix_ce_q <= 1'b0;
            hpos_q <= '0;    vpos_q <= '0;
            wpix_q <= '0;    vaddr_q <= '0;
            word_q <= '0;    sel_q <= '0;
            act1_q <= 1'b0;  hb1_q <= 1'b1;  vb1_q <= 1'b1;
            hs1_q <= 1'b0;   vs1_q <= 1'b0;  fs1_q <= 1'b0;
            out_q <= '0;     pix_q <= '0;
            hsync_q <= ~SYNC_POL; vsync_q <= ~SYNC_POL;
            hblank_q <= 1'b1;     vblank_q <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_q <= div_d;       pix_ce_q <= pix_ce_d;
            hpos_q <= hpos_d;     vpos_q <= vpos_d;
            wpix_q <= wpix_d;     vaddr_q <= vaddr_d;
            word_q <= word_d;     sel_q <= sel_d;
            act1_q <= act1_d;     hb1_q <= hb1_d;  vb1_q <= vb1_d;
            hs1_q <= hs1_d;       vs1_q <= vs1_d;  fs1_q <= fs1_d;
            out_q <= out_d;       pix_q <= pix_d;
            hsync_q <= hsync_d;   vsync_q <= vsync_d;
            hblank_q <= hblank_d; vblank_q <= vblank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign out         = out_q;
    assign r           = pix_q;
    assign g           = pix_q;
    assign b           = pix_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign pix_ce      = pix_ce_q;
    assign frame_start = frame_start_q;
endmodule
